sqrt_sequencer: RTL and testbench
=================================

Name: sqrt_sequencer

Overview:
Control FSM that drives the FP square-root datapath's control word: IE, WE, OE, register addresses and ALU_Op. It consumes the ALU negative_o and zero_o flags and computes an integer square root by odd-number subtraction (N - 1 - 3 - 5 ...) inside the 8x32 register file. It exposes a start/busy/done handshake to the host, plus a load selector for the constant mux that feeds data_i.

Parameters:
MAX_ITER, 46341, maximum number of successful subtract iterations before an error is flagged.
ITER_W, 16, width of the iteration counter; must satisfy 2^ITER_W > MAX_ITER.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  request; sampled only in IDLE
negative_i  in  1  ALU sign flag (combinational from current RDA/RDB/ALU_Op)
zero_i  in  1  ALU zero flag; reserved, unused by this algorithm
IE  out  1  1 = register file writes data_i, 0 = writes ALU_o
WE  out  1  register file write enable
OE  out  1  output register capture enable
ADDR_WR  out  3  write address
ADDR_RDA  out  3  read port A address
ADDR_RDB  out  3  read port B address
ALU_Op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
load_sel_o  out  2  data_i source: 0 operand N, 1 constant 1, 2 constant 2
busy_o  out  1  high from the cycle after start is accepted through DONE/ERR
done_o  out  1  one-cycle completion pulse
error_o  out  1  one-cycle pulse, coincident with done_o, on error

Behaviour:
- Reset: state IDLE; IE=WE=OE=0; all addresses 0; ALU_Op=ADD; load_sel_o=0; busy_o=done_o=error_o=0.
- Registers: R1 = remainder, R2 = odd, R3 = 2, R4 = quotient, R6 = 1, R7 = 0.
- Outputs are Moore-decoded from state. The only exception is WE in SUB, which is gated by negative_i.
- States and control words:
  - IDLE: all outputs idle. If start_i, go to LD_N; otherwise stay.
  - LD_N: IE=1, WE=1, WR=R1, sel=0.
  - LD_ODD: IE=1, WE=1, WR=R2, sel=1.
  - LD_ONE: IE=1, WE=1, WR=R6, sel=1.
  - LD_TWO: IE=1, WE=1, WR=R3, sel=2.
  - CLR_Q: WE=1, WR=R4, A=R2, B=R6, SUB.
  - CLR_Z: WE=1, WR=R7, A=R2, B=R6, SUB.
  - CHK: WE=0, A=R1, B=R7, SUB. If negative_i, go to ERR; else go to SUB. Iteration counter cleared.
  - SUB: A=R1, B=R2, SUB, WR=R1.
    - If negative_i: WE=0, go to OUT.
    - Else if iter_cnt==MAX_ITER: WE=0, go to ERR.
    - Else: WE=1, iter_cnt+1, go to INC_Q.
  - INC_Q: WE=1, WR=R4, A=R4, B=R6, ADD.
  - INC_ODD: WE=1, WR=R2, A=R2, B=R3, ADD. Go to SUB.
  - OUT: OE=1, A=R4, B=R7, ADD, so the output register captures the quotient.
  - DONE: done_o=1. Go to IDLE.
  - ERR: done_o=1, error_o=1. Go to IDLE.
- busy_o is high in every state except IDLE.
- Latency: start sampled at cycle t. For a quotient q, done_o is high at t+10+3q and data_o is valid from that same cycle.
  - N=0 completes at t+10.
  - Negative N gives ERR at t+8.
- start_i outside IDLE is ignored and is not queued.
- Reset mid-operation returns to IDLE immediately. Register file and data_o contents are then don't-care.
- N is treated as signed 32-bit; the valid range is 0..2^31-1.

Decomposition:
- Shared package sqrt_seq_pkg holds:
  - state encoding (14 states);
  - ALU opcode constants;
  - register index constants R1..R7;
  - load_sel codes.
- No sub-module: state register, iteration counter and output decode live in one module.

Test Plan:
- N=16 (sel 0 → 16, sel 1 → 1, sel 2 → 2 via bench mux): done_o at t+22, data_o=4, error_o=0, busy_o high t+1..t+22.
- N=0: done_o at t+10, data_o=0. N=15: data_o=3, done at t+19.
- N=0xFFFFFFFB: done_o and error_o pulse at t+8; no write in CHK.
- MAX_ITER=2, N=100: third SUB at t+14 sees the limit; error pulse at t+15; WE=0 in that SUB.
- Assert rst at t+12 during N=16: all outputs at reset values in the same cycle. A new start then completes normally with data_o=4.
- Hold start_i high throughout N=9: exactly one run, done at t+19, data_o=3. Re-accept occurs only after returning to IDLE.

Source files
------------

// File: rtl/sqrt_seq_pkg.sv
// Shared definitions for the integer square-root sequencer.
//   state_e      : sequencer states (14)
//   ALU_*        : ALU opcode encodings driven on ALU_Op
//   R1..R7       : register-file indices used by the algorithm
//   SEL_*        : load_sel_o codes for the constant mux feeding data_i
package sqrt_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_N,
    S_LD_ODD,
    S_LD_ONE,
    S_LD_TWO,
    S_CLR_Q,
    S_CLR_Z,
    S_CHK,
    S_SUB,
    S_INC_Q,
    S_INC_ODD,
    S_OUT,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // R1 remainder, R2 current odd, R3 constant 2, R4 quotient,
  // R6 constant 1, R7 constant 0
  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam logic [1:0] SEL_N   = 2'd0;
  localparam logic [1:0] SEL_ONE = 2'd1;
  localparam logic [1:0] SEL_TWO = 2'd2;

endpackage

// File: rtl/sqrt_sequencer.sv
// Control FSM for the square-root datapath. Computes floor(sqrt(N)) by
// repeatedly subtracting successive odd numbers from N in the register file
// and counting successful subtractions.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   start_i             : request, sampled only in IDLE
//   negative_i, zero_i  : ALU flags (zero_i is not needed by this algorithm)
//   IE, WE, OE          : register-file input select / write enable, output capture
//   ADDR_WR/RDA/RDB     : register-file addresses
//   ALU_Op              : ALU opcode
//   load_sel_o          : data_i source (N, const 1, const 2)
//   busy_o, done_o, error_o : host handshake
module sqrt_sequencer
  import sqrt_seq_pkg::*;
#(
  parameter int MAX_ITER = 46341,
  parameter int ITER_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       negative_i,
  input  logic       zero_i,
  output logic       IE,
  output logic       WE,
  output logic       OE,
  output logic [2:0] ADDR_WR,
  output logic [2:0] ADDR_RDA,
  output logic [2:0] ADDR_RDB,
  output logic [1:0] ALU_Op,
  output logic [1:0] load_sel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic unused_zero;
  assign unused_zero = zero_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    IE         = 1'b0;
    WE         = 1'b0;
    OE         = 1'b0;
    ADDR_WR    = R0;
    ADDR_RDA   = R0;
    ADDR_RDB   = R0;
    ALU_Op     = ALU_ADD;
    load_sel_o = SEL_N;
    busy_o     = (state_q != S_IDLE);
    done_o     = 1'b0;
    error_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LD_N;
      end
      S_LD_N: begin
        IE = 1'b1; WE = 1'b1; ADDR_WR = R1; load_sel_o = SEL_N;
        state_d = S_LD_ODD;
      end
      S_LD_ODD: begin
        IE = 1'b1; WE = 1'b1; ADDR_WR = R2; load_sel_o = SEL_ONE;
        state_d = S_LD_ONE;
      end
      S_LD_ONE: begin
        IE = 1'b1; WE = 1'b1; ADDR_WR = R6; load_sel_o = SEL_ONE;
        state_d = S_LD_TWO;
      end
      S_LD_TWO: begin
        IE = 1'b1; WE = 1'b1; ADDR_WR = R3; load_sel_o = SEL_TWO;
        state_d = S_CLR_Q;
      end
      // No direct zero load exists: 1 - 1 through the ALU yields zero.
      S_CLR_Q: begin
        WE = 1'b1; ADDR_WR = R4; ADDR_RDA = R2; ADDR_RDB = R6; ALU_Op = ALU_SUB;
        state_d = S_CLR_Z;
      end
      S_CLR_Z: begin
        WE = 1'b1; ADDR_WR = R7; ADDR_RDA = R2; ADDR_RDB = R6; ALU_Op = ALU_SUB;
        state_d = S_CHK;
      end
      // N - 0 exposes the sign of N on negative_i without writing anything.
      S_CHK: begin
        ADDR_RDA = R1; ADDR_RDB = R7; ALU_Op = ALU_SUB;
        iter_d   = '0;
        state_d  = negative_i ? S_ERR : S_SUB;
      end
      // Remainder - odd: the write is suppressed when it would go negative
      // (we are finished) or when the iteration budget is exhausted.
      S_SUB: begin
        ADDR_WR = R1; ADDR_RDA = R1; ADDR_RDB = R2; ALU_Op = ALU_SUB;
        if (negative_i) begin
          state_d = S_OUT;
        end else if (iter_q == ITER_LIMIT) begin
          state_d = S_ERR;
        end else begin
          WE      = 1'b1;
          iter_d  = iter_q + 1'b1;
          state_d = S_INC_Q;
        end
      end
      S_INC_Q: begin
        WE = 1'b1; ADDR_WR = R4; ADDR_RDA = R4; ADDR_RDB = R6; ALU_Op = ALU_ADD;
        state_d = S_INC_ODD;
      end
      S_INC_ODD: begin
        WE = 1'b1; ADDR_WR = R2; ADDR_RDA = R2; ADDR_RDB = R3; ALU_Op = ALU_ADD;
        state_d = S_SUB;
      end
      // Quotient + 0 routes R4 through the ALU into the output register.
      S_OUT: begin
        OE = 1'b1; ADDR_RDA = R4; ADDR_RDB = R7; ALU_Op = ALU_ADD;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done_o  = 1'b1;
        error_o = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Bench for sqrt_sequencer: two DUT instances (default MAX_ITER and
// MAX_ITER=2), each wrapped in a behavioural register file / ALU / output
// register so the sequencer computes real square roots.
module tb_sqrt_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       start;
  logic [1:0][31:0] n_val;
  logic [1:0]       ie, we, oe, busy, done, error;
  logic [1:0][2:0]  wr, ra, rb;
  logic [1:0][1:0]  op, sel;
  logic [1:0][31:0] dout;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int MI = (g == 0) ? 46341 : 2;
    logic [31:0] rf [8];
    logic [31:0] alu, din, dout_r;

    always_comb begin
      alu = '0;
      case (op[g])
        2'b00: alu = rf[ra[g]] + rf[rb[g]];
        2'b01: alu = rf[ra[g]] - rf[rb[g]];
        2'b10: alu = rf[ra[g]] & rf[rb[g]];
        default: alu = rf[ra[g]] | rf[rb[g]];
      endcase
    end

    always_comb begin
      din = '0;
      case (sel[g])
        2'd0: din = n_val[g];
        2'd1: din = 32'd1;
        2'd2: din = 32'd2;
        default: din = '0;
      endcase
    end

    always @(posedge clk) begin
      if (we[g]) rf[wr[g]] <= ie[g] ? din : alu;
      if (oe[g]) dout_r <= alu;
    end
    assign dout[g] = dout_r;

    sqrt_sequencer #(.MAX_ITER(MI), .ITER_W(16)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start[g]),
      .negative_i (alu[31]),
      .zero_i     (alu == 32'd0),
      .IE         (ie[g]),
      .WE         (we[g]),
      .OE         (oe[g]),
      .ADDR_WR    (wr[g]),
      .ADDR_RDA   (ra[g]),
      .ADDR_RDB   (rb[g]),
      .ALU_Op     (op[g]),
      .load_sel_o (sel[g]),
      .busy_o     (busy[g]),
      .done_o     (done[g]),
      .error_o    (error[g])
    );
  end

  int          passed = 0;
  int          total  = 0;
  int          lat;
  logic [31:0] q_r;
  logic        err_r;
  bit          busy_ok;
  logic        pre_busy;
  bit          we_tr [0:255];

  // Start one run on instance k from IDLE; records latency (cycles after
  // the start-sampling cycle), result, and a WE trace indexed by cycle.
  task automatic run(input int k, input logic [31:0] n);
    @(posedge clk); #1;
    n_val[k] = n;
    start[k] = 1'b1;
    lat      = -1;
    busy_ok  = 1'b1;
    q_r      = 'x;
    err_r    = 1'bx;
    pre_busy = busy[k];
    for (int i = 0; i < 256; i++) we_tr[i] = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start[k] = 1'b0;
      we_tr[c] = we[k];
      if (!busy[k]) busy_ok = 1'b0;
      if (done[k]) begin
        lat   = c;
        q_r   = dout[k];
        err_r = error[k];
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({ie[k], we[k], oe[k]} !== 3'b000)
        $display("FAIL reset_ctl[%0d]: got %b want 000", k, {ie[k], we[k], oe[k]});
      else passed++;
      total++;
      if ({wr[k], ra[k], rb[k]} !== 9'd0)
        $display("FAIL reset_addr[%0d]: got %h want 000", k, {wr[k], ra[k], rb[k]});
      else passed++;
      total++;
      if ({op[k], sel[k]} !== 4'd0)
        $display("FAIL reset_op_sel[%0d]: got %h want 0", k, {op[k], sel[k]});
      else passed++;
      total++;
      if ({busy[k], done[k], error[k]} !== 3'b000)
        $display("FAIL reset_hs[%0d]: got %b want 000", k, {busy[k], done[k], error[k]});
      else passed++;
    end
  endtask

  task automatic test_sqrt_basic();
    run(0, 32'd16);
    total++; if (pre_busy !== 1'b0) $display("FAIL n16_prebusy: got %b want 0", pre_busy); else passed++;
    total++; if (lat !== 22) $display("FAIL n16_latency: got %0d want 22", lat); else passed++;
    total++; if (q_r !== 32'd4) $display("FAIL n16_result: got %0d want 4", q_r); else passed++;
    total++; if (err_r !== 1'b0) $display("FAIL n16_error: got %b want 0", err_r); else passed++;
    total++; if (busy_ok !== 1'b1) $display("FAIL n16_busy: got dropout want high t+1..t+22"); else passed++;
    @(posedge clk); #1;
    total++;
    if ({busy[0], done[0]} !== 2'b00)
      $display("FAIL n16_after: got busy,done=%b want 00", {busy[0], done[0]});
    else passed++;

    run(0, 32'd0);
    total++; if (lat !== 10) $display("FAIL n0_latency: got %0d want 10", lat); else passed++;
    total++; if (q_r !== 32'd0) $display("FAIL n0_result: got %0d want 0", q_r); else passed++;

    run(0, 32'd15);
    total++; if (lat !== 19) $display("FAIL n15_latency: got %0d want 19", lat); else passed++;
    total++; if (q_r !== 32'd3) $display("FAIL n15_result: got %0d want 3", q_r); else passed++;

    run(0, 32'd1);
    total++; if (lat !== 13) $display("FAIL n1_latency: got %0d want 13", lat); else passed++;
    total++; if (q_r !== 32'd1) $display("FAIL n1_result: got %0d want 1", q_r); else passed++;
  endtask

  task automatic test_negative();
    run(0, 32'hFFFF_FFFB);
    total++; if (lat !== 8) $display("FAIL neg_latency: got %0d want 8", lat); else passed++;
    total++; if (err_r !== 1'b1) $display("FAIL neg_error: got %b want 1", err_r); else passed++;
    total++; if (we_tr[7] !== 1'b0) $display("FAIL neg_chk_we: got %b want 0", we_tr[7]); else passed++;
    @(posedge clk); #1;
    total++; if (error[0] !== 1'b0) $display("FAIL neg_err_pulse: got %b want 0", error[0]); else passed++;
  endtask

  task automatic test_max_iter();
    run(1, 32'd100);
    total++; if (lat !== 15) $display("FAIL lim_latency: got %0d want 15", lat); else passed++;
    total++; if (err_r !== 1'b1) $display("FAIL lim_error: got %b want 1", err_r); else passed++;
    total++; if (we_tr[14] !== 1'b0) $display("FAIL lim_sub_we: got %b want 0", we_tr[14]); else passed++;
    total++; if (we_tr[11] !== 1'b1) $display("FAIL lim_sub2_we: got %b want 1", we_tr[11]); else passed++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    n_val[0] = 32'd16;
    start[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    // cycle t+12 is INC_Q: a write to R4 is in progress
    total++; if (we[0] !== 1'b1) $display("FAIL mid_pre_we: got %b want 1", we[0]); else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({ie[0], we[0], oe[0], wr[0], ra[0], rb[0], op[0], sel[0], busy[0], done[0], error[0]} !== 19'd0)
      $display("FAIL mid_reset_outs: got %h want 0",
               {ie[0], we[0], oe[0], wr[0], ra[0], rb[0], op[0], sel[0], busy[0], done[0], error[0]});
    else passed++;
    #2;
    rst = 1'b0;
    run(0, 32'd16);
    total++; if (lat !== 22) $display("FAIL mid_rerun_latency: got %0d want 22", lat); else passed++;
    total++; if (q_r !== 32'd4) $display("FAIL mid_rerun_result: got %0d want 4", q_r); else passed++;
  endtask

  task automatic test_hold_start();
    int   first, second, ndone;
    logic b20, b21;
    logic [31:0] q1, q2;
    first = -1; second = -1; ndone = 0; b20 = 1'bx; b21 = 1'bx; q1 = 'x; q2 = 'x;
    @(posedge clk); #1;
    n_val[0] = 32'd9;
    start[0] = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 21) start[0] = 1'b0;
      if (c == 20) b20 = busy[0];
      if (c == 21) b21 = busy[0];
      if (done[0]) begin
        ndone++;
        if (first < 0) begin first = c; q1 = dout[0]; end
        else if (second < 0) begin second = c; q2 = dout[0]; end
      end
    end
    total++; if (first !== 19) $display("FAIL hold_first_done: got %0d want 19", first); else passed++;
    total++; if (q1 !== 32'd3) $display("FAIL hold_first_result: got %0d want 3", q1); else passed++;
    total++; if (b20 !== 1'b0) $display("FAIL hold_idle_gap: got %b want 0", b20); else passed++;
    total++; if (b21 !== 1'b1) $display("FAIL hold_reaccept: got %b want 1", b21); else passed++;
    total++; if (second !== 39) $display("FAIL hold_second_done: got %0d want 39", second); else passed++;
    total++; if (q2 !== 32'd3) $display("FAIL hold_second_result: got %0d want 3", q2); else passed++;
    total++; if (ndone !== 2) $display("FAIL hold_done_count: got %0d want 2", ndone); else passed++;
  endtask

  initial begin
    start = '0;
    n_val = '0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_sqrt_basic();
    test_negative();
    test_max_iter();
    test_reset_mid();
    test_hold_start();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
